// File: rtl/matrix_writeback_unit.sv
// Streams an MxN result matrix row-major into RAM, one word per cycle, starting at a base address.
// Optional running checksum of written words when WRITEBACK_CHECKSUM_EN is defined.
module matrix_writeback_unit #(
  parameter int DIM    = 32,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_address,
  input  logic [5:0]        matrix_M,
  input  logic [5:0]        matrix_N,
  input  logic [DATA_W-1:0] matrix_in [0:DIM-1][0:DIM-1],
  input  logic              hold,
  output logic              write_block,
  output logic [ADDR_W-1:0] address_block,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              error
`ifdef WRITEBACK_CHECKSUM_EN
  , output logic [DATA_W-1:0] checksum
`endif
);

  localparam int         IDX_W   = $clog2(DIM);
  localparam logic [5:0] DIM_MAX = 6'(DIM);

  typedef enum logic [1:0] {IDLE, WRITE, FINISH} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [ADDR_W-1:0] offset_reg, offset_next;
  logic [5:0]        m_reg, m_next;
  logic [5:0]        n_reg, n_next;
  logic [5:0]        i_reg, i_next;
  logic [5:0]        j_reg, j_next;
  logic              write_block_reg, write_block_next;
  logic [ADDR_W-1:0] address_reg, address_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              error_reg, error_next;
  logic [DATA_W-1:0] checksum_reg, checksum_next;

  logic              dims_ok;
  logic [DATA_W-1:0] element;

  assign dims_ok = (matrix_M != 6'd0) && (matrix_M <= DIM_MAX) &&
                   (matrix_N != 6'd0) && (matrix_N <= DIM_MAX);
  assign element = matrix_in[i_reg[IDX_W-1:0]][j_reg[IDX_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      base_reg        <= '0;
      offset_reg      <= '0;
      m_reg           <= '0;
      n_reg           <= '0;
      i_reg           <= '0;
      j_reg           <= '0;
      write_block_reg <= 1'b0;
      address_reg     <= '0;
      data_reg        <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      error_reg       <= 1'b0;
      checksum_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      base_reg        <= base_next;
      offset_reg      <= offset_next;
      m_reg           <= m_next;
      n_reg           <= n_next;
      i_reg           <= i_next;
      j_reg           <= j_next;
      write_block_reg <= write_block_next;
      address_reg     <= address_next;
      data_reg        <= data_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      error_reg       <= error_next;
      checksum_reg    <= checksum_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    base_next        = base_reg;
    offset_next      = offset_reg;
    m_next           = m_reg;
    n_next           = n_reg;
    i_next           = i_reg;
    j_next           = j_reg;
    write_block_next = 1'b0;
    address_next     = address_reg;
    data_next        = data_reg;
    busy_next        = busy_reg;
    done_next        = 1'b0;
    error_next       = 1'b0;
    checksum_next    = checksum_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (dims_ok) begin
            base_next     = base_address;
            m_next        = matrix_M;
            n_next        = matrix_N;
            i_next        = '0;
            j_next        = '0;
            offset_next   = '0;
            checksum_next = '0;
            busy_next     = 1'b1;
            state_next    = WRITE;
          end else begin
            error_next = 1'b1;
          end
        end
      end
      WRITE: begin
        if (!hold) begin
          // Running offset replaces base+i*N+j; ADDR_W-wide add wraps for free.
          write_block_next = 1'b1;
          address_next     = base_reg + offset_reg;
          data_next        = element;
          offset_next      = offset_reg + 1'b1;
          checksum_next    = checksum_reg + element;
          if (j_reg == n_reg - 6'd1) begin
            j_next = '0;
            i_next = i_reg + 6'd1;
            if (i_reg == m_reg - 6'd1)
              state_next = FINISH;
          end else begin
            j_next = j_reg + 6'd1;
          end
        end
      end
      FINISH: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign write_block   = write_block_reg;
  assign address_block = address_reg;
  assign data_out      = data_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign error         = error_reg;
`ifdef WRITEBACK_CHECKSUM_EN
  assign checksum      = checksum_reg;
`else
  // Accumulator only feeds the optional port; it is trimmed when absent.
  logic unused_checksum;
  assign unused_checksum = ^checksum_reg;
`endif

endmodule

// File: tb/tb_matrix_writeback_unit.sv
// Directed self-checking bench for matrix_writeback_unit; outputs sampled on the falling edge.
// Set WRITEBACK_CHECKSUM_EN to also check the checksum port.
module tb_matrix_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [19:0] base_address;
  logic [5:0]  matrix_M;
  logic [5:0]  matrix_N;
  logic [15:0] mat [0:31][0:31];
  logic        hold;
  logic        write_block;
  logic [19:0] address_block;
  logic [15:0] data_out;
  logic        busy;
  logic        done;
  logic        error;
`ifdef WRITEBACK_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [19:0] wa_q[$];
  logic [15:0] wd_q[$];

  always #5 clk = ~clk;

  matrix_writeback_unit dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_address(base_address),
    .matrix_M(matrix_M),
    .matrix_N(matrix_N),
    .matrix_in(mat),
    .hold(hold),
    .write_block(write_block),
    .address_block(address_block),
    .data_out(data_out),
    .busy(busy),
    .done(done),
    .error(error)
`ifdef WRITEBACK_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always @(negedge clk) begin
    if (write_block) begin
      wa_q.push_back(address_block);
      wd_q.push_back(data_out);
    end
    if (done) done_cnt++;
    if (error) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts a transfer and counts falling edges until done; optional hold window and a second start.
  task automatic run_xfer(input logic [19:0] base, input logic [5:0] m, input logic [5:0] n,
                          input int hold_at, input int hold_len, input int restart_at,
                          output int lat);
    bit seen;
    seen = 1'b0;
    lat = 0;
    @(negedge clk);
    base_address = base;
    matrix_M = m;
    matrix_N = n;
    start = 1'b1;
    for (int k = 1; k <= 1200 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        check("busy_after_start", busy, 1);
      end
      if (restart_at > 0 && k == restart_at) begin
        start = 1'b1;
        base_address = 20'd999;
      end
      if (restart_at > 0 && k == restart_at + 1) start = 1'b0;
      if (hold_len > 0) begin
        if (k == hold_at) hold = 1'b1;
        if (k == hold_at + hold_len) hold = 1'b0;
        if (k > hold_at && k <= hold_at + hold_len) check("wb_during_hold", write_block, 0);
      end
      if (done) begin
        seen = 1'b1;
        lat = k;
        check("busy_at_done", busy, 0);
      end
    end
    start = 1'b0;
    hold = 1'b0;
    if (!seen) check("done_timeout", 0, 1);
    @(negedge clk);
    check("done_single_cycle", done, 0);
    $display("xfer base=%05h MxN=%0dx%0d latency=%0d writes=%0d", base, m, n, lat, wa_q.size());
  endtask

  task automatic check_writes(input string tag, input logic [19:0] base, input int m, input int n);
    int cnt;
    cnt = (wa_q.size() < m * n) ? wa_q.size() : m * n;
    check({tag, "_count"}, wa_q.size(), m * n);
    for (int idx = 0; idx < cnt; idx++) begin
      check({tag, "_addr"}, wa_q[idx], base + 20'(idx));
      check({tag, "_data"}, wd_q[idx], mat[idx / n][idx % n]);
    end
  endtask

  initial begin
    int lat;
    int done_before;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++)
        mat[i][j] = 16'hA000 ^ 16'((i << 8) | j);
    rst = 1'b1;
    start = 1'b0;
    hold = 1'b0;
    base_address = '0;
    matrix_M = '0;
    matrix_N = '0;
    #2;
    check("rst_wb", write_block, 0);
    check("rst_addr", address_block, 0);
    check("rst_data", data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
`ifdef WRITEBACK_CHECKSUM_EN
    check("rst_checksum", checksum, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Basic 2x2 at base 5
    mat[0][0] = 16'd1; mat[0][1] = 16'd2; mat[1][0] = 16'd3; mat[1][1] = 16'd4;
    wa_q.delete(); wd_q.delete();
    run_xfer(20'd5, 6'd2, 6'd2, 0, 0, 0, lat);
    check("basic_latency", lat, 6);
    check("basic_count", wa_q.size(), 4);
    if (wa_q.size() == 4) begin
      check("basic_a0", wa_q[0], 20'd5); check("basic_d0", wd_q[0], 16'd1);
      check("basic_a1", wa_q[1], 20'd6); check("basic_d1", wd_q[1], 16'd2);
      check("basic_a2", wa_q[2], 20'd7); check("basic_d2", wd_q[2], 16'd3);
      check("basic_a3", wa_q[3], 20'd8); check("basic_d3", wd_q[3], 16'd4);
    end
    check("basic_busy_after", busy, 0);
    check("basic_done_cnt", done_cnt, 1);
`ifdef WRITEBACK_CHECKSUM_EN
    check("basic_checksum", checksum, 16'd10);
`endif

    // 1x3 with hold on the second issue edge for two cycles
    wa_q.delete(); wd_q.delete();
    run_xfer(20'd0, 6'd1, 6'd3, 2, 2, 0, lat);
    check("stall_latency", lat, 7);
    check_writes("stall", 20'd0, 1, 3);

    // Illegal dimensions
    wa_q.delete(); wd_q.delete();
    @(negedge clk);
    matrix_M = 6'd0; matrix_N = 6'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ill0_error", error, 1);
    check("ill0_busy", busy, 0);
    @(negedge clk);
    check("ill0_error_pulse", error, 0);
    matrix_M = 6'd33; matrix_N = 6'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ill33_error", error, 1);
    check("ill33_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("ill_error_cnt", err_cnt, 2);
    check("ill_no_writes", wa_q.size(), 0);
    check("ill_busy_after", busy, 0);
    $display("xfer illegal dims: errors=%0d writes=%0d", err_cnt, wa_q.size());

    // Address wrap
    wa_q.delete(); wd_q.delete();
    run_xfer(20'hFFFFE, 6'd1, 6'd4, 0, 0, 0, lat);
    check("wrap_latency", lat, 6);
    check("wrap_count", wa_q.size(), 4);
    if (wa_q.size() == 4) begin
      check("wrap_a0", wa_q[0], 20'hFFFFE);
      check("wrap_a1", wa_q[1], 20'hFFFFF);
      check("wrap_a2", wa_q[2], 20'h00000);
      check("wrap_a3", wa_q[3], 20'h00001);
    end

    // Second start while busy is ignored
    wa_q.delete(); wd_q.delete();
    run_xfer(20'd100, 6'd4, 6'd4, 0, 0, 5, lat);
    check("busy_start_latency", lat, 18);
    check_writes("busy_start", 20'd100, 4, 4);
    check("busy_start_no_error", err_cnt, 2);

    // Reset in the middle of a 32x32 transfer, after 100 writes
    wa_q.delete(); wd_q.delete();
    done_before = done_cnt;
    @(negedge clk);
    base_address = 20'd0; matrix_M = 6'd32; matrix_N = 6'd32; start = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check("mid_rst_wb", write_block, 0);
    check("mid_rst_addr", address_block, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
`ifdef WRITEBACK_CHECKSUM_EN
    check("mid_rst_checksum", checksum, 0);
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_writes", wa_q.size(), 100);
    if (wa_q.size() == 100) check("mid_rst_last_addr", wa_q[99], 20'd99);
    check("mid_rst_no_done", done_cnt, done_before);
    check("mid_rst_idle", busy, 0);
    $display("xfer reset mid-transfer: writes=%0d done=%0d", wa_q.size(), done_cnt - done_before);

    // 1x1 after reset
    mat[0][0] = 16'hBEEF;
    wa_q.delete(); wd_q.delete();
    run_xfer(20'd7, 6'd1, 6'd1, 0, 0, 0, lat);
    check("post_rst_latency", lat, 3);
    check("post_rst_count", wa_q.size(), 1);
    if (wa_q.size() == 1) begin
      check("post_rst_addr", wa_q[0], 20'd7);
      check("post_rst_data", wd_q[0], 16'hBEEF);
    end
`ifdef WRITEBACK_CHECKSUM_EN
    check("post_rst_checksum", checksum, 16'hBEEF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
